// File: rtl/mdu_pkg.sv
// mdu_pkg: funct3 codes, FSM encoding and opcode constants
// shared by the execute-stage multiply/divide unit and alu.
package mdu_pkg;

  localparam logic [6:0] OP_RTYPE_W = 7'b0111011;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

  function automatic logic mdu_is_div(logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement of a W-bit value.
// Used for operand magnitudes and result sign fix-up.
module mdu_negate #(
  parameter int W = 64
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mdu.sv
// mdu: iterative RV64M/RV32M multiply/divide unit, one bit
// per cycle, valid/ready in and out, flush aborts.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_w,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res
);

  localparam int CW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;

  mdu_state_e state_q, state_d;

  logic [2:0]      op_q, op_d;
  logic            w_q, w_d;
  logic            neg_q, neg_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            n32, is_div;
  logic            a_sgn, b_sgn, sa, sb;
  logic            b_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] most_neg, spec_val;
  logic [W2-1:0]   prod, prod_s;
  logic [XLEN-1:0] prod_hi;
  logic [XLEN-1:0] dv_raw, dv_s, fix_res;
  logic [XLEN:0]   sum, rem_sh, diff;
  logic            ge;

  function automatic logic [XLEN-1:0] wfix(
    input logic            w,
    input logic [XLEN-1:0] v
  );
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = vld_q;
  assign out_res   = res_q;

  assign n32    = w_q | (XLEN == 32);
  assign is_div = mdu_is_div(op_q);

  assign a_sgn = (op_q == MDU_MULH) | (op_q == MDU_MULHSU)
               | (op_q == MDU_DIV)  | (op_q == MDU_REM);
  assign b_sgn = (op_q == MDU_MULH) | (op_q == MDU_DIV)
               | (op_q == MDU_REM);

  assign a_ext = !w_q ? a_q :
                 a_sgn ? XLEN'($signed(a_q[31:0])) :
                         XLEN'(a_q[31:0]);
  assign b_ext = !w_q ? b_q :
                 b_sgn ? XLEN'($signed(b_q[31:0])) :
                         XLEN'(b_q[31:0]);

  assign sa = a_sgn & a_ext[XLEN-1];
  assign sb = b_sgn & b_ext[XLEN-1];

  mdu_negate #(.W(XLEN)) u_neg_a (
    .neg_i (sa),
    .val_i (a_ext),
    .res_o (a_mag)
  );

  mdu_negate #(.W(XLEN)) u_neg_b (
    .neg_i (sb),
    .val_i (b_ext),
    .res_o (b_mag)
  );

  assign most_neg = n32 ? XLEN'($signed(32'h8000_0000))
                        : {1'b1, {(XLEN-1){1'b0}}};
  assign b_zero   = (b_ext == '0);
  assign ovf      = !op_q[0] & (a_ext == most_neg) & (&b_ext);
  assign spec_val = b_zero ? (op_q[1] ? a_ext : '1)
                           : (op_q[1] ? '0 : a_ext);

  // multiply: add at bit XLEN then shift right; word ops end
  // up scaled by 2^(XLEN-32), undone in FIX
  assign sum = {1'b0, acc_q[W2-1:XLEN]}
             + (acc_q[0] ? {1'b0, a_q} : '0);

  // divide: remainder always < 2*divisor, so diff msb is borrow
  assign rem_sh = acc_q[W2-1:XLEN-1];
  assign diff   = rem_sh - {1'b0, b_q};
  assign ge     = ~diff[XLEN];

  assign prod = n32 ? (acc_q >> (XLEN-32)) : acc_q;

  mdu_negate #(.W(W2)) u_neg_p (
    .neg_i (neg_q),
    .val_i (prod),
    .res_o (prod_s)
  );

  assign prod_hi = n32 ? XLEN'(prod_s[63:32])
                       : prod_s[W2-1:XLEN];
  assign dv_raw  = op_q[1] ? acc_q[W2-1:XLEN]
                           : acc_q[XLEN-1:0];

  mdu_negate #(.W(XLEN)) u_neg_d (
    .neg_i (neg_q),
    .val_i (dv_raw),
    .res_o (dv_s)
  );

  assign fix_res = is_div ? dv_s :
                   (op_q == MDU_MUL) ? prod_s[XLEN-1:0] :
                   prod_hi;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    w_d     = w_q;
    neg_d   = neg_q;
    vld_d   = vld_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d    = in_op;
            w_d     = in_w & (XLEN == 64);
            a_d     = in_a;
            b_d     = in_b;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          a_d   = a_mag;
          b_d   = b_mag;
          neg_d = (op_q[2] & op_q[1]) ? sa : (sa ^ sb);
          cnt_d = n32 ? CW'(31) : CW'(XLEN-1);
          acc_d = is_div
                ? {{XLEN{1'b0}},
                   (n32 ? (a_mag << (XLEN-32)) : a_mag)}
                : {{XLEN{1'b0}}, b_mag};
          if (is_div & (b_zero | ovf)) begin
            res_d   = wfix(w_q, spec_val);
            vld_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          acc_d = is_div
                ? {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                   acc_q[XLEN-2:0], ge}
                : {sum, acc_q[XLEN-1:1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_FIX: begin
          res_d   = wfix(w_q, fix_res);
          vld_d   = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      w_q     <= 1'b0;
      neg_q   <= 1'b0;
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      w_q     <= w_d;
      neg_q   <= neg_d;
      vld_q   <= vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and random checks of mdu (XLEN=64)
// against an arithmetic reference model.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_w;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;

  int total = 0;
  int bad   = 0;

  mdu #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_w      (in_w),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] op,
    input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic [31:0]  a32, b32;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      case (op)
        MDU_MUL:  return sx32(a32 * b32);
        MDU_DIV:
          if (b32 == 0) return '1;
          else if (a32 == 32'h8000_0000 && b32 == '1)
            return sx32(a32);
          else return sx32($signed(a32) / $signed(b32));
        MDU_DIVU: return (b32 == 0) ? '1 : sx32(a32 / b32);
        MDU_REM:
          if (b32 == 0) return sx32(a32);
          else if (a32 == 32'h8000_0000 && b32 == '1) return 0;
          else return sx32($signed(a32) % $signed(b32));
        MDU_REMU: return (b32 == 0) ? sx32(a32) : sx32(a32 % b32);
        default:  return 'x;
      endcase
    end
    case (op)
      MDU_MUL: return a * b;
      MDU_MULH, MDU_MULHSU, MDU_MULHU: begin
        pa = (op != MDU_MULHU) ? {{64{a[63]}}, a} : {64'd0, a};
        pb = (op == MDU_MULH)  ? {{64{b[63]}}, b} : {64'd0, b};
        p  = pa * pb;
        return p[127:64];
      end
      MDU_DIV:
        if (b == 0) return '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        else return $signed(a) / $signed(b);
      MDU_DIVU: return (b == 0) ? '1 : a / b;
      MDU_REM:
        if (b == 0) return a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) return 0;
        else return $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
    input logic w, input logic [63:0] a, input logic [63:0] b);
    logic z, o;
    z = w ? (b[31:0] == 0) : (b == 0);
    o = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
          : (a == 64'h8000_0000_0000_0000 && b == '1);
    if (op[2] && (z || (!op[0] && o))) return 2;
    return w ? 35 : 67;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic wait_res(output logic [63:0] res, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_res;
  endtask

  task automatic run_op(input logic [2:0] op, input logic w,
    input logic [63:0] a, input logic [63:0] b,
    output logic [63:0] res, output int lat);
    @(negedge clk);
    in_op = op; in_w = w; in_a = a; in_b = b;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_res(res, lat);
    @(posedge clk); #1;
  endtask

  task automatic do_dir(input string tag, input logic [2:0] op,
    input logic w, input logic [63:0] a, input logic [63:0] b,
    input logic [63:0] exp, input int exp_lat);
    logic [63:0] r;
    int          l;
    run_op(op, w, a, b, r, l);
    chk(tag, r, exp);
    chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
  endtask

  task automatic start_op(input logic [2:0] op,
    input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_op = op; in_w = 1'b0; in_a = a; in_b = b;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] r, ra;
    logic [2:0]  op;
    logic        w;
    int          l, n;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_w = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_res", out_res, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    do_dir("mul", MDU_MUL, 0, 7, -64'sd3,
           64'hFFFF_FFFF_FFFF_FFEB, 67);
    do_dir("mulhu", MDU_MULHU, 0, '1, '1,
           64'hFFFF_FFFF_FFFF_FFFE, 67);
    do_dir("mulhsu", MDU_MULHSU, 0, '1, 2, '1, 67);
    do_dir("mulh", MDU_MULH, 0, 64'h8000_0000_0000_0000, 2,
           '1, 67);
    do_dir("div0", MDU_DIV, 0, 5, 0, '1, 2);
    do_dir("rem0", MDU_REM, 0, 5, 0, 5, 2);
    do_dir("div_ovf", MDU_DIV, 0, 64'h8000_0000_0000_0000, '1,
           64'h8000_0000_0000_0000, 2);
    do_dir("rem_ovf", MDU_REM, 0, 64'h8000_0000_0000_0000, '1,
           0, 2);
    do_dir("divw", MDU_DIV, 1, 64'h1234_5678_FFFF_FFF9, 2,
           64'hFFFF_FFFF_FFFF_FFFD, 35);
    do_dir("remw", MDU_REM, 1, 64'h1234_5678_FFFF_FFF9, 2,
           '1, 35);
    do_dir("mulw", MDU_MUL, 1, 64'h4000_0000, 2,
           64'hFFFF_FFFF_8000_0000, 35);

    // backpressure: result held, new request ignored
    @(negedge clk);
    in_op = MDU_MULHU; in_w = 1'b0; in_a = '1; in_b = '1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_res(r, l);
    chk("bp_res", r, 64'hFFFF_FFFF_FFFF_FFFE);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_op = MDU_DIVU; in_a = 100; in_b = 7; in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_res !== r || out_valid !== 1'b1 || in_ready !== 1'b0)
        n++;
    end
    chk("bp_hold", 64'(n), 64'd0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_rdy", 64'(in_ready), 64'd1);
    chk("bp_idle_vld", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", 64'(in_ready), 64'd0);
    wait_res(r, l);
    chk("bp_next", r, 64'd14);
    chk("bp_next_lat", 64'(l), 64'd67);
    @(posedge clk); #1;

    // flush in CALC cycle 10
    start_op(MDU_DIVU, '1, 3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_rdy", 64'(in_ready), 64'd1);
    chk("flush_vld", 64'(out_valid), 64'd0);
    n = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("flush_quiet", 64'(n), 64'd0);
    do_dir("post_flush", MDU_DIVU, 0, 100, 7, 14, 67);

    // reset mid-CALC
    start_op(MDU_MUL, 64'h1234, 64'h5678);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_rdy", 64'(in_ready), 64'd1);
    chk("mrst_vld", 64'(out_valid), 64'd0);
    chk("mrst_res", out_res, 64'd0);
    do_dir("post_rst", MDU_DIVU, 0, 100, 7, 14, 67);

    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = (op == MDU_MUL || op[2]) ? 1'($urandom_range(0, 1))
                                    : 1'b0;
      ra = pick();
      r  = pick();
      do_dir($sformatf("rnd%0d_op%0d_w%0d", i, op, w), op, w,
             ra, r, ref_res(op, w, ra, r), ref_lat(op, w, ra, r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
